// File: rtl/mult_resp_pkg.sv
// Shared definitions for the word-serial multiply responder.
//   mult_resp_state_t : control states of the responder FSM
//   ndig()            : number of operand-B digits needed to cover an
//                       (out_bits+1)-bit operand with digit_bits-wide slices
package mult_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } mult_resp_state_t;

  // Guarded so that an illegal digit width still elaborates far enough to
  // reach the parameter check in the top level.
  function automatic int ndig(input int out_bits, input int digit_bits);
    if (digit_bits < 1) begin
      return 1;
    end
    return (out_bits + digit_bits) / digit_bits;
  endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Minimal AXI-stream style channel shared by requester and responder blocks.
//   val/rdy : handshake, a beat transfers when both are high on a clock edge
//   dat     : DAT_BITS payload
//   ctl     : CTL_BITS sideband tag, passed through by the responder
//   sop/eop : start/end of packet markers
//   err     : error flag
//   mod     : count of invalid bytes in the last beat
interface if_axi_stream #(
  parameter int DAT_BITS = 8,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = (DAT_BITS > 15) ? $clog2(DAT_BITS / 8) : 1
) ();

  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic [MOD_BITS-1:0] mod;

  modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);

endinterface

// File: rtl/mult_resp_serial_digit_mac.sv
// One Horner step of the serial multiplier: sum = (acc << DIGIT_BITS) + a*digit.
// Purely combinational and kept in its own module so it can be retimed or
// mapped onto DSP cascades without touching the control logic.
//   acc   : running accumulator, ACC_BITS wide
//   a     : full-width operand A
//   digit : current DIGIT_BITS slice of operand B
//   sum   : next accumulator value
module digit_mac
  import mult_resp_pkg::*;
#(
  parameter int ACC_BITS   = 516,
  parameter int A_BITS     = 257,
  parameter int DIGIT_BITS = 17
) (
  input  logic [ACC_BITS-1:0]   acc,
  input  logic [A_BITS-1:0]     a,
  input  logic [DIGIT_BITS-1:0] digit,
  output logic [ACC_BITS-1:0]   sum
);

  localparam int PP_BITS = A_BITS + DIGIT_BITS;

  logic [PP_BITS-1:0] partial;

  assign partial = a * digit;

  // The accumulator never uses its top bits, so the left shift cannot lose
  // product information.
  assign sum = (acc << DIGIT_BITS) + {{(ACC_BITS - PP_BITS){1'b0}}, partial};

endmodule

// File: rtl/mult_resp_serial.sv
// Word-serial multiply responder. Accepts one request (A, B, ctl) at a time,
// accumulates A*B over NDIG cycles most-significant B digit first, then
// presents the product until the sink takes it.
//   i_clk     : single clock
//   i_rst_n   : asynchronous active-low reset
//   i_mult_if : request stream, dat[0 +: OUT_BITS+1] = A,
//               dat[OUT_BITS+1 +: OUT_BITS+1] = B
//   o_mult_if : product stream, dat = A*B zero-extended, ctl echoed,
//               single-beat packets (sop = eop = 1)
module mult_resp_serial
  import mult_resp_pkg::*;
#(
  parameter int OUT_BITS   = 256,
  parameter int CTL_BITS   = 8,
  parameter int DIGIT_BITS = 17
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  if_axi_stream.sink    i_mult_if,
  if_axi_stream.source  o_mult_if
);

  localparam int A_BITS   = OUT_BITS + 1;
  localparam int DAT_BITS = 2 * (OUT_BITS + 2);
  localparam int NDIG     = ndig(OUT_BITS, DIGIT_BITS);
  localparam int B_BITS   = NDIG * DIGIT_BITS;
  localparam int CNT_BITS = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NDIG - 1);

  if (DIGIT_BITS < 1 || DIGIT_BITS > OUT_BITS + 1) begin : g_bad_digit_bits
    $fatal(1, "mult_resp_serial: DIGIT_BITS must lie in 1..OUT_BITS+1");
  end

  mult_resp_state_t state, state_nxt;

  logic [A_BITS-1:0]   a_q;
  logic [B_BITS-1:0]   b_q;
  logic [CTL_BITS-1:0] ctl_q;
  logic [DAT_BITS-1:0] acc_q;
  logic [DAT_BITS-1:0] mac_sum;
  logic [CNT_BITS-1:0] cnt_q;
  logic                in_rdy_q;
  logic                out_val_q;

  logic accept;
  logic mult_last;
  logic out_fire;

  // B is shifted left each MULT cycle, so its top slice is always the digit
  // the Horner recurrence needs next.
  digit_mac #(
    .ACC_BITS   (DAT_BITS),
    .A_BITS     (A_BITS),
    .DIGIT_BITS (DIGIT_BITS)
  ) u_digit_mac (
    .acc   (acc_q),
    .a     (a_q),
    .digit (b_q[B_BITS-1 -: DIGIT_BITS]),
    .sum   (mac_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mult_last = 1'b0;
    out_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (in_rdy_q && i_mult_if.val) begin
          accept    = 1'b1;
          state_nxt = MULT;
        end
      end
      MULT: begin
        if (cnt_q == LAST_CNT) begin
          mult_last = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_val_q && o_mult_if.rdy) begin
          out_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rdy is registered from the next state: it rises on the edge that returns
  // the FSM to IDLE (including the output handshake edge, which gives the
  // NDIG+2 back-to-back period) and drops on the accepting edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      ctl_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      in_rdy_q  <= 1'b0;
      out_val_q <= 1'b0;
    end else begin
      in_rdy_q <= (state_nxt == IDLE);
      if (accept) begin
        a_q   <= i_mult_if.dat[0 +: A_BITS];
        b_q   <= B_BITS'(i_mult_if.dat[A_BITS +: A_BITS]);
        ctl_q <= i_mult_if.ctl;
        acc_q <= '0;
        cnt_q <= '0;
      end
      if (state == MULT) begin
        acc_q <= mac_sum;
        b_q   <= b_q << DIGIT_BITS;
        cnt_q <= cnt_q + 1'b1;
      end
      if (mult_last) begin
        out_val_q <= 1'b1;
      end else if (out_fire) begin
        out_val_q <= 1'b0;
      end
    end
  end

  assign i_mult_if.rdy = in_rdy_q;

  // acc and ctl are frozen in DONE, so the product beat stays stable under
  // backpressure without a separate output register.
  assign o_mult_if.val = out_val_q;
  assign o_mult_if.dat = acc_q;
  assign o_mult_if.ctl = ctl_q;
  assign o_mult_if.sop = out_val_q;
  assign o_mult_if.eop = out_val_q;
  assign o_mult_if.err = 1'b0;
  assign o_mult_if.mod = '0;

endmodule

// File: tb/tb_mult_resp_serial.sv
// Self-checking bench for mult_resp_serial at default parameters
// (OUT_BITS=256, DIGIT_BITS=17, so 16 digits and an 18-cycle period).
module tb_mult_resp_serial;

  localparam int OUT_BITS = 256;
  localparam int A_BITS   = OUT_BITS + 1;
  localparam int DAT_BITS = 2 * (OUT_BITS + 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  int compared   = 0;
  int mismatched = 0;

  logic [A_BITS-1:0]   allOnes;
  logic [DAT_BITS-1:0] maxProd;
  logic [DAT_BITS-1:0] expProd;
  logic [A_BITS-1:0]   ra;
  logic [A_BITS-1:0]   rb;
  int                  acceptCyc;
  int                  prevAccept;

  if_axi_stream #(.DAT_BITS(DAT_BITS), .CTL_BITS(8)) reqIf ();
  if_axi_stream #(.DAT_BITS(DAT_BITS), .CTL_BITS(8)) resIf ();

  mult_resp_serial #(
    .OUT_BITS   (OUT_BITS),
    .CTL_BITS   (8),
    .DIGIT_BITS (17)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_mult_if (reqIf),
    .o_mult_if (resIf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [DAT_BITS-1:0] got,
                             input logic [DAT_BITS-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [A_BITS-1:0] rand257();
    logic [A_BITS-1:0] r;
    r = '0;
    for (int j = 0; j < 9; j++) begin
      r = (r << 32) | A_BITS'($urandom);
    end
    return r;
  endfunction

  // Presents a request from the current negedge and holds it until accepted;
  // returns the cycle count just before the accepting edge.
  task automatic applyStimulus(input logic [A_BITS-1:0] a, input logic [A_BITS-1:0] b,
                               input logic [7:0] ctl, output int accCyc);
    int budget;
    reqIf.val = 1'b1;
    reqIf.dat = {2'b00, b, a};
    reqIf.ctl = ctl;
    budget = 0;
    while (!reqIf.rdy && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    if (!reqIf.rdy) begin
      checkOutput("accept_timeout", 0, 1);
      accCyc = -1;
      reqIf.val = 1'b0;
      return;
    end
    accCyc = cyc;
    @(negedge clk);
    reqIf.val = 1'b0;
  endtask

  // Called at the negedge after the accepting edge. With holdCycles == 0 the
  // sink is ready throughout and the task returns while the product is valid.
  task automatic awaitProduct(input string tag, input logic [DAT_BITS-1:0] expDat,
                              input logic [7:0] expCtl, input int holdCycles);
    int k;
    resIf.rdy = (holdCycles == 0);
    k = 0;
    while (!resIf.val && k < 64) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_latency"}, k, 16);
    if (!resIf.val) return;
    checkOutput({tag, "_dat"}, resIf.dat, expDat);
    checkOutput({tag, "_ctl"}, resIf.ctl, expCtl);
    checkOutput({tag, "_sop"}, resIf.sop, 1);
    checkOutput({tag, "_eop"}, resIf.eop, 1);
    checkOutput({tag, "_err"}, resIf.err, 0);
    checkOutput({tag, "_mod"}, resIf.mod, 0);
    checkOutput({tag, "_reqrdy"}, reqIf.rdy, 0);
    if (holdCycles > 0) begin
      for (int i = 0; i < holdCycles; i++) begin
        @(negedge clk);
        checkOutput({tag, "_hold_val"}, resIf.val, 1);
        checkOutput({tag, "_hold_dat"}, resIf.dat, expDat);
        checkOutput({tag, "_hold_ctl"}, resIf.ctl, expCtl);
        checkOutput({tag, "_hold_reqrdy"}, reqIf.rdy, 0);
      end
      resIf.rdy = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_val_drop"}, resIf.val, 0);
      checkOutput({tag, "_reqrdy_back"}, reqIf.rdy, 1);
    end
  endtask

  initial begin
    reqIf.val = 1'b0;
    reqIf.dat = '0;
    reqIf.ctl = '0;
    reqIf.sop = 1'b0;
    reqIf.eop = 1'b0;
    reqIf.err = 1'b0;
    reqIf.mod = '0;
    resIf.rdy = 1'b0;
    allOnes = '1;
    maxProd = (516'd1 << 514) - (516'd1 << 258) + 516'd1;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_reqrdy", reqIf.rdy, 0);
    checkOutput("rst_val", resIf.val, 0);
    checkOutput("rst_dat", resIf.dat, 0);
    checkOutput("rst_ctl", resIf.ctl, 0);
    checkOutput("rst_sop", resIf.sop, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_rdy_low", reqIf.rdy, 0);
    @(negedge clk);
    checkOutput("release_rdy_high", reqIf.rdy, 1);

    $display("[TB] small product");
    applyStimulus(257'd3, 257'd5, 8'hA5, acceptCyc);
    awaitProduct("small", 516'd15, 8'hA5, 0);

    $display("[TB] maximum operands");
    applyStimulus(allOnes, allOnes, 8'h3C, acceptCyc);
    awaitProduct("max", maxProd, 8'h3C, 0);
    checkOutput("max_top_bits", resIf.dat[515:514], 0);

    $display("[TB] zero and one");
    applyStimulus(257'd0, allOnes, 8'h01, acceptCyc);
    awaitProduct("zero", 516'd0, 8'h01, 0);
    applyStimulus(257'd1, 257'h1_2345, 8'h02, acceptCyc);
    awaitProduct("one", 516'h1_2345, 8'h02, 0);

    $display("[TB] backpressure");
    applyStimulus(257'd123456789, 257'd987654321, 8'h77, acceptCyc);
    awaitProduct("bp", 516'd121932631112635269, 8'h77, 20);

    $display("[TB] back-to-back");
    prevAccept = 0;
    for (int i = 0; i < 100; i++) begin
      ra = rand257();
      rb = rand257();
      expProd = ra * rb;
      applyStimulus(ra, rb, 8'(i), acceptCyc);
      if (i > 0) checkOutput("b2b_spacing", acceptCyc - prevAccept, 18);
      prevAccept = acceptCyc;
      awaitProduct("b2b", expProd, 8'(i), 0);
    end

    $display("[TB] reset mid-MULT");
    applyStimulus(allOnes, allOnes, 8'h11, acceptCyc);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_val", resIf.val, 0);
    checkOutput("midrst_dat", resIf.dat, 0);
    checkOutput("midrst_reqrdy", reqIf.rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_release_rdy_low", reqIf.rdy, 0);
    @(negedge clk);
    checkOutput("midrst_release_rdy_high", reqIf.rdy, 1);
    checkOutput("midrst_no_stale_val", resIf.val, 0);
    applyStimulus(257'd2, 257'd7, 8'h5A, acceptCyc);
    awaitProduct("after_rst", 516'd14, 8'h5A, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
